calc_sequencer: RTL and testbench

- Keypad-driven controller that sequences one calculation: digit entry for operand A, operator entry, digit entry for operand B, then ALU launch.
- Issues a start/done handshake to the mini ALU, captures its result and sign, and selects what the display encoder shows.
- Sits between the debounced key decoder and the ALU/display-encoder path in the calculator top.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/calc_sequencer_if.sv | 31 +++
 rtl/calc_sequencer_digit_accum.sv | 53 +++++
 rtl/calc_sequencer.sv | 150 +++++++++++++++
 tb/tb_calc_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_pkg : key codes, operator/state enums, size defaults          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package calc_pkg;
   localparam int DIGITS_DEF = 4;
   localparam int OP_W_DEF   = 14;

   localparam logic [3:0] KEY_ADD = 4'd10;
   localparam logic [3:0] KEY_SUB = 4'd11;
   localparam logic [3:0] KEY_MUL = 4'd12;
   localparam logic [3:0] KEY_DIV = 4'd13;
   localparam logic [3:0] KEY_EQ  = 4'd14;
   localparam logic [3:0] KEY_CLR = 4'd15;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'd0,
      ST_ENTER_B = 3'd1,
      ST_EXEC    = 3'd2,
      ST_WAIT    = 3'd3,
      ST_SHOW    = 3'd4,
      ST_ERR     = 3'd5
   } state_e;

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam int DEC_MAX = pow10(DIGITS_DEF) - 1;
endpackage
`default_nettype wire

// File: rtl/calc_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_sequencer_if : key input, ALU handshake and display bundle    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface calc_sequencer_if #(parameter int OP_W = 14);
   logic            key_valid;
   logic [3:0]      key_code;
   logic [OP_W-1:0] op1;
   logic [OP_W-1:0] op2;
   logic [1:0]      operation;
   logic            alu_start;
   logic            alu_done;
   logic [OP_W-1:0] alu_result;
   logic            alu_sign;
   logic [OP_W-1:0] disp_value;
   logic            disp_neg;
   logic            err;
   logic            busy;

   modport master (
      input  key_valid, key_code, alu_done, alu_result, alu_sign,
      output op1, op2, operation, alu_start, disp_value, disp_neg, err, busy
   );

   modport slave (
      output key_valid, key_code, alu_done, alu_result, alu_sign,
      input  op1, op2, operation, alu_start, disp_value, disp_neg, err, busy
   );
endinterface
`default_nettype wire

// File: rtl/calc_sequencer_digit_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | digit_accum : one decimal operand accumulator with digit counter   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module digit_accum #(
   parameter int DIGITS = 4,
   parameter int OP_W   = 14
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_zero,
   input  logic            push_digit,
   input  logic [3:0]      digit,
   input  logic            load_en,
   input  logic [OP_W-1:0] load_data,
   output logic [OP_W-1:0] value
);
   localparam int CNT_W = $clog2(DIGITS + 1);

   logic [OP_W-1:0]  r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [OP_W-1:0]  w_base;
   logic [CNT_W-1:0] w_cnt;
   logic             w_significant;

   // load_zero with push_digit means "restart the operand with this digit"
   always_comb begin
      w_base        = load_zero ? '0 : r_acc;
      w_cnt         = load_zero ? '0 : r_cnt;
      w_significant = (w_base != '0) || (digit != 4'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (load_en) begin
         // a chained result is a finished operand: no digits may be appended
         r_acc <= load_data;
         r_cnt <= CNT_W'(DIGITS);
      end else if (push_digit && (w_cnt < CNT_W'(DIGITS))) begin
         r_acc <= w_base * OP_W'(10) + OP_W'(digit);
         r_cnt <= w_cnt + (w_significant ? CNT_W'(1) : CNT_W'(0));
      end else if (load_zero) begin
         r_acc <= '0;
         r_cnt <= '0;
      end
   end

   assign value = r_acc;
endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | calc_sequencer : keypad entry -> ALU launch -> result display FSM  |
// | Optional macro RESULT_CHAIN_EN: operator key in SHOW chains result |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF,
   parameter int OP_W   = OP_W_DEF
) (
   input logic              clk,
   input logic              rst,
   calc_sequencer_if.master bus
);
   localparam logic [OP_W-1:0] C_DEC_MAX = OP_W'(pow10(DIGITS) - 1);

   state_e          r_state, w_state_n;
   op_e             r_op, w_op_n;
   logic [OP_W-1:0] r_res, w_res_n;
   logic            r_neg, w_neg_n;
   logic            w_a_zero, w_a_push, w_a_load, w_b_zero, w_b_push;
   logic [OP_W-1:0] w_op1, w_op2;
   logic            w_digit, w_oper, w_eq, w_clr, w_div0;

   digit_accum #(.DIGITS(DIGITS), .OP_W(OP_W)) u_acc_a (
      .clk(clk), .rst(rst), .load_zero(w_a_zero), .push_digit(w_a_push),
      .digit(bus.key_code), .load_en(w_a_load), .load_data(r_res), .value(w_op1)
   );

   digit_accum #(.DIGITS(DIGITS), .OP_W(OP_W)) u_acc_b (
      .clk(clk), .rst(rst), .load_zero(w_b_zero), .push_digit(w_b_push),
      .digit(bus.key_code), .load_en(1'b0), .load_data('0), .value(w_op2)
   );

   always_comb begin
      w_digit = bus.key_valid && (bus.key_code < KEY_ADD);
      w_oper  = bus.key_valid && (bus.key_code >= KEY_ADD) && (bus.key_code <= KEY_DIV);
      w_eq    = bus.key_valid && (bus.key_code == KEY_EQ);
      w_clr   = bus.key_valid && (bus.key_code == KEY_CLR);
      w_div0  = (r_op == OP_DIV) && (w_op2 == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_ENTER_A;
         r_op    <= OP_ADD;
         r_res   <= '0;
         r_neg   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_op    <= w_op_n;
         r_res   <= w_res_n;
         r_neg   <= w_neg_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_op_n    = r_op;
      w_res_n   = r_res;
      w_neg_n   = r_neg;
      w_a_zero  = 1'b0;
      w_a_push  = 1'b0;
      w_a_load  = 1'b0;
      w_b_zero  = 1'b0;
      w_b_push  = 1'b0;
      if (w_clr && (r_state != ST_WAIT)) begin
         w_state_n = ST_ENTER_A;
         w_op_n    = OP_ADD;
         w_res_n   = '0;
         w_neg_n   = 1'b0;
         w_a_zero  = 1'b0 | 1'b1;
         w_b_zero  = 1'b1;
      end else begin
         case (r_state)
            ST_ENTER_A: begin
               if (w_digit) begin
                  w_a_push = 1'b1;
               end else if (w_oper) begin
                  w_op_n    = op_e'(2'(bus.key_code - KEY_ADD));
                  w_b_zero  = 1'b1;
                  w_state_n = ST_ENTER_B;
               end
            end
            ST_ENTER_B: begin
               if (w_digit) begin
                  w_b_push = 1'b1;
               end else if (w_oper) begin
                  w_op_n = op_e'(2'(bus.key_code - KEY_ADD));
               end else if (w_eq) begin
                  w_state_n = ST_EXEC;
               end
            end
            ST_EXEC: begin
               w_state_n = w_div0 ? ST_ERR : ST_WAIT;
            end
            ST_WAIT: begin
               // the ALU saturates to all ones on overflow, which exceeds C_DEC_MAX
               if (bus.alu_done) begin
                  if (bus.alu_result > C_DEC_MAX) begin
                     w_state_n = ST_ERR;
                  end else begin
                     w_res_n   = bus.alu_result;
                     w_neg_n   = bus.alu_sign;
                     w_state_n = ST_SHOW;
                  end
               end
            end
            ST_SHOW: begin
               if (w_digit) begin
                  w_a_zero  = 1'b1;
                  w_a_push  = 1'b1;
                  w_state_n = ST_ENTER_A;
               end else if (w_eq) begin
                  w_state_n = ST_EXEC;
               end
`ifdef RESULT_CHAIN_EN
               else if (w_oper) begin
                  w_a_load  = 1'b1;
                  w_op_n    = op_e'(2'(bus.key_code - KEY_ADD));
                  w_b_zero  = 1'b1;
                  w_neg_n   = 1'b0;
                  w_state_n = ST_ENTER_B;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.op1        = w_op1;
      bus.op2        = w_op2;
      bus.operation  = r_op;
      bus.alu_start  = (r_state == ST_EXEC) && !w_div0;
      bus.busy       = (r_state == ST_EXEC) || (r_state == ST_WAIT);
      bus.err        = (r_state == ST_ERR);
      bus.disp_neg   = (r_state == ST_SHOW) && r_neg;
      case (r_state)
         ST_ENTER_A:                    bus.disp_value = w_op1;
         ST_ENTER_B, ST_EXEC, ST_WAIT:  bus.disp_value = w_op2;
         ST_SHOW:                       bus.disp_value = r_res;
         default:                       bus.disp_value = '0;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_calc_sequencer : directed + random key sequences vs a keypad    |
// | and ALU reference model; honours RESULT_CHAIN_EN. Rev 1.0          |
// +--------------------------------------------------------------------+
module tb_calc_sequencer;
   import calc_pkg::*;

   localparam int DIGITS = 4;
   localparam int OP_W   = 14;
   localparam int MAXV   = 9999;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   calc_sequencer_if #(.OP_W(OP_W)) bus ();

   calc_sequencer #(.DIGITS(DIGITS), .OP_W(OP_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = k;
      @(negedge clk);
      bus.key_valid = 1'b0;
   endtask

   task automatic press_digits(input int d[$]);
      foreach (d[i]) press(4'(d[i]));
   endtask

   // Operand a keypad produces: leading zeros vanish, then the first DIGITS digits count.
   function automatic int entry_value(input int d[$]);
      int v = 0;
      int taken = 0;
      bit started = 0;
      foreach (d[i]) begin
         if (d[i] != 0) started = 1;
         if (started && taken < DIGITS) begin
            v = v * 10 + d[i];
            taken++;
         end
      end
      return v;
   endfunction

   // Called in the EXEC cycle right after '=' was pressed.
   task automatic exec_check(input string tag, input int a, input int b, input int op,
                             input int lat, input int key_i, input logic [3:0] key_c);
      int  r;
      bit  s;
      bit  ovf;
      int  k;
      int  busy_cnt;
      int  starts;
      s = 0;
      case (op)
         0: r = a + b;
         1: begin r = (a >= b) ? a - b : b - a; s = (b > a); end
         2: r = a * b;
         default: r = (b == 0) ? 0 : a / b;
      endcase
      ovf = (r > MAXV);
      if (op == 3 && b == 0) begin
         starts = 0;
         for (int i = 0; i < 3; i++) begin
            starts += int'(bus.alu_start);
            @(negedge clk);
         end
         check({tag, "_div0_start"}, starts, 0);
         check({tag, "_div0_err"}, bus.err, 1);
         check({tag, "_div0_busy"}, bus.busy, 0);
         return;
      end
      k = 0;
      while (!bus.alu_start && k < 10) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_start_seen"}, bus.alu_start, 1);
      if (!bus.alu_start) return;
      check({tag, "_op1"}, bus.op1, a);
      check({tag, "_op2"}, bus.op2, b);
      check({tag, "_operation"}, bus.operation, op);
      busy_cnt = int'(bus.busy);
      starts   = 1;
      for (int i = 1; i <= lat; i++) begin
         @(negedge clk);
         bus.key_valid = 1'b0;
         busy_cnt += int'(bus.busy);
         starts   += int'(bus.alu_start);
         if (i == key_i) begin
            bus.key_valid = 1'b1;
            bus.key_code  = key_c;
         end
         if (i == lat) begin
            bus.alu_done   = 1'b1;
            bus.alu_result = ovf ? {OP_W{1'b1}} : OP_W'(r);
            bus.alu_sign   = s;
         end
      end
      @(negedge clk);
      bus.alu_done  = 1'b0;
      bus.key_valid = 1'b0;
      busy_cnt += int'(bus.busy);
      check({tag, "_busy_cycles"}, busy_cnt, lat + 1);
      check({tag, "_start_pulses"}, starts, 1);
      if (ovf) begin
         check({tag, "_ovf_err"}, bus.err, 1);
      end else begin
         check({tag, "_result"}, bus.disp_value, r);
         check({tag, "_neg"}, bus.disp_neg, s);
         check({tag, "_err"}, bus.err, 0);
      end
   endtask

   initial begin
      int qa[$];
      int qb[$];
      int a, b, op;

      rst = 1'b1;
      bus.key_valid = 1'b0; bus.key_code = 4'd0;
      bus.alu_done = 1'b0; bus.alu_result = '0; bus.alu_sign = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_disp", bus.disp_value, 0);
      check("rst_op1", bus.op1, 0);
      check("rst_op2", bus.op2, 0);
      check("rst_operation", bus.operation, 0);
      check("rst_flags", {bus.alu_start, bus.disp_neg, bus.err, bus.busy}, 0);
      rst = 1'b0;

      // 12 + 34, ALU answers 3 cycles after launch; clear during WAIT is ignored
      press_digits('{1, 2});
      check("a12_disp", bus.disp_value, 12);
      press(KEY_ADD);
      press_digits('{3, 4});
      check("b34_disp", bus.disp_value, 34);
      press(KEY_EQ);
      exec_check("add", 12, 34, 0, 3, 1, KEY_CLR);
      press(4'd5);
      check("show_digit_disp", bus.disp_value, 5);
      check("show_digit_op1", bus.op1, 5);

      // 5 - 9 with a digit key colliding with alu_done
      press(KEY_CLR);
      press_digits('{5}); press(KEY_SUB); press_digits('{9}); press(KEY_EQ);
      exec_check("sub", 5, 9, 1, 2, 2, 4'd8);

      // divide by zero, then a digit is ignored, then clear recovers
      press(KEY_CLR);
      press_digits('{7}); press(KEY_DIV); press_digits('{0}); press(KEY_EQ);
      exec_check("div0", 7, 0, 3, 1, -1, 4'd0);
      press(4'd3);
      check("err_digit_err", bus.err, 1);
      press(KEY_CLR);
      check("err_clear_err", bus.err, 0);
      check("err_clear_disp", bus.disp_value, 0);

      // digit limit and leading zeros
      press_digits('{1, 2, 3, 4, 5});
      check("limit_disp", bus.disp_value, 1234);
      press(KEY_CLR);
      press_digits('{0, 0, 7});
      check("lead0_disp", bus.disp_value, 7);
      press_digits('{1, 2, 3, 4});
      check("lead0_full_disp", bus.disp_value, 7123);

      // multiply overflow
      press(KEY_CLR);
      press_digits('{9, 9, 9}); press(KEY_MUL); press_digits('{9, 9}); press(KEY_EQ);
      exec_check("mulovf", 999, 99, 2, 2, -1, 4'd0);
      press(KEY_CLR);

      // reset during WAIT abandons the operation
      press_digits('{1}); press(KEY_ADD); press_digits('{2}); press(KEY_EQ);
      @(negedge clk);
      check("rstwait_busy_before", bus.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.alu_done = 1'b1; bus.alu_result = OP_W'(3); bus.alu_sign = 1'b1;
      @(negedge clk);
      bus.alu_done = 1'b0;
      check("rstwait_disp", bus.disp_value, 0);
      check("rstwait_flags", {bus.busy, bus.disp_neg, bus.err}, 0);
      press(4'd3);
      check("rstwait_enter_a", bus.disp_value, 3);

      // operator key in SHOW
      press(KEY_CLR);
      press_digits('{6}); press(KEY_MUL); press_digits('{7}); press(KEY_EQ);
      exec_check("mul", 6, 7, 2, 2, -1, 4'd0);
      press(KEY_ADD);
`ifdef RESULT_CHAIN_EN
      check("chain_disp_cleared", bus.disp_value, 0);
      press_digits('{8}); press(KEY_EQ);
      exec_check("chain", 42, 8, 0, 2, -1, 4'd0);
      press(KEY_CLR);
      press_digits('{5}); press(KEY_SUB); press_digits('{9}); press(KEY_EQ);
      exec_check("chainneg_a", 5, 9, 1, 1, -1, 4'd0);
      press(KEY_ADD);
      check("chainneg_negclr", bus.disp_neg, 0);
      press_digits('{1}); press(KEY_EQ);
      exec_check("chainneg_b", 4, 1, 0, 1, -1, 4'd0);
`else
      check("nochain_disp", bus.disp_value, 42);
      check("nochain_busy", bus.busy, 0);
      press(KEY_EQ);
      exec_check("nochain_reexec", 6, 7, 2, 2, -1, 4'd0);
`endif

      // random calculations against the reference model
      for (int n = 0; n < 10; n++) begin
         press(KEY_CLR);
         qa.delete(); qb.delete();
         repeat ($urandom_range(1, 6)) qa.push_back(int'($urandom_range(0, 9)));
         repeat ($urandom_range(1, 6)) qb.push_back(int'($urandom_range(0, 9)));
         a  = entry_value(qa);
         b  = entry_value(qb);
         op = int'($urandom_range(0, 3));
         if (op == 0 && a + b > MAXV) op = 1;
         press_digits(qa);
         check("rnd_a_disp", bus.disp_value, a);
         press(4'(int'(KEY_ADD) + op));
         check("rnd_opkey_disp", bus.disp_value, 0);
         press_digits(qb);
         check("rnd_b_disp", bus.disp_value, b);
         press(KEY_EQ);
         exec_check("rnd", a, b, op, int'($urandom_range(1, 4)), -1, 4'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
